// File: rtl/wb_bram_slave.sv
// -----------------------------------------------------------------------------
// wb_bram_slave
//   Wishbone B4 pipelined responder backed by an inferred block RAM.
//   It stands in for the SDRAM target so the JTAG-to-Wishbone initiator can be
//   exercised with configurable read latency and optional pseudo-random stalls.
//
// Parameters
//   AW         bus word-address width
//   DW         bus data width (multiple of 8)
//   MAW        RAM address bits; depth = 2**MAW; upper address bits alias
//   LATENCY    cycles from acceptance to ack (1..8)
//   STALL_SEED LFSR reset value (nonzero)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   wb_cyc_i      bus cycle; dropping it aborts every pending ack
//   wb_stb_i      request strobe
//   wb_we_i       1 = write, 0 = read
//   wb_adr_i      word address
//   wb_dat_i      write data
//   wb_sel_i      byte enables (writes only)
//   wb_dat_o      read data, held between read acks
//   wb_ack_o      one pulse per accepted request, in order
//   wb_stall_o    request not accepted this cycle
//   cfg_stall_en  enable pseudo-random stall injection
// -----------------------------------------------------------------------------
module wb_bram_slave #(
   parameter int         AW         = 24,
   parameter int         DW         = 16,
   parameter int         MAW        = 10,
   parameter int         LATENCY    = 2,
   parameter logic [7:0] STALL_SEED = 8'hA5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_stall_o,
   input  logic            cfg_stall_en
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 2 ** MAW;

   logic             accept;
   logic [MAW-1:0]   addr;
   logic [DW-1:0]    mem [0:DEPTH-1];
   logic [DW-1:0]    d_q [1:LATENCY];   // stage 1 doubles as the RAM output register
   logic [LATENCY:1] v_q;
   logic [LATENCY:1] we_q;
   logic [DW-1:0]    dat_hold_q;
   logic             ack_live;
   logic [7:0]       lfsr_q;
   logic             stall_q;

   assign addr   = wb_adr_i[MAW-1:0];
   assign accept = wb_cyc_i & wb_stb_i & ~stall_q;

   // Address bits above MAW only alias onto the same word.
   generate
      if (AW > MAW) begin : g_adr_hi
         logic unused_adr_hi;
         assign unused_adr_hi = ^wb_adr_i[AW-1:MAW];
      end
   endgenerate

   // RAM array, read register and read-data pipeline.
   // NOTE: memories and pure datapath registers carry no reset; a reset here
   // would prevent block-RAM inference, and the valid bits qualify the data.
   always_ff @(posedge clk) begin
      if (accept && wb_we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (wb_sel_i[b]) mem[addr][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
      if (accept && !wb_we_i) d_q[1] <= mem[addr];
      for (int k = 2; k <= LATENCY; k++) d_q[k] <= d_q[k-1];
   end

   // Ack pipeline control: valid and write flags shift one stage per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q  <= '0;
         we_q <= '0;
      end else begin
         v_q[1]  <= accept;
         we_q[1] <= wb_we_i;
         for (int k = 2; k <= LATENCY; k++) begin
            v_q[k]  <= v_q[k-1];
            we_q[k] <= we_q[k-1];
         end
         // NOTE: the later non-blocking assignment wins, so an abort overrides
         // the shift above and flushes every pending ack at this edge.
         if (!wb_cyc_i) v_q <= '0;
      end
   end

   // The ack is qualified by wb_cyc_i so that no ack escapes in the very cycle
   // the initiator abandons the bus cycle.
   assign ack_live = v_q[LATENCY] & wb_cyc_i;
   assign wb_ack_o = ack_live;
   assign wb_dat_o = (ack_live && !we_q[LATENCY]) ? d_q[LATENCY] : dat_hold_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dat_hold_q <= '0;
      else        dat_hold_q <= wb_dat_o;
   end

   // Stall injection: 8-bit Fibonacci LFSR (taps 8,6,5,4), frozen while
   // disabled; the stall flag is registered and asserted ~25% of cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q  <= STALL_SEED;
         stall_q <= 1'b0;
      end else begin
         if (cfg_stall_en) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         stall_q <= cfg_stall_en & lfsr_q[0] & lfsr_q[1];
      end
   end

   assign wb_stall_o = stall_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_bram_slave
//   Directed and randomized bench for wb_bram_slave (default parameters).
//   A transaction-level model keeps a word array and a queue of expected
//   responses stamped with their acceptance cycle; each cycle it predicts
//   wb_ack_o, wb_dat_o and the stall-off rule.
// -----------------------------------------------------------------------------
module tb_wb_bram_slave;

   localparam int AW  = 24;
   localparam int DW  = 16;
   localparam int MAW = 10;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wb_cyc_i = 1'b0;
   logic          wb_stb_i = 1'b0;
   logic          wb_we_i = 1'b0;
   logic [AW-1:0] wb_adr_i = '0;
   logic [DW-1:0] wb_dat_i = '0;
   logic [1:0]    wb_sel_i = '0;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o;
   logic          wb_stall_o;
   logic          cfg_stall_en = 1'b0;

   always #5 clk = ~clk;

   wb_bram_slave #(
      .AW(AW), .DW(DW), .MAW(MAW), .LATENCY(LAT), .STALL_SEED(8'hA5)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
      .cfg_stall_en(cfg_stall_en)
   );

   typedef struct {
      int            t;
      bit            we;
      logic [DW-1:0] d;
   } resp_t;

   resp_t         rq[$];
   logic [DW-1:0] mem_m [0:(1<<MAW)-1];
   logic [DW-1:0] dat_exp = '0;
   int            checks = 0;
   int            errors = 0;
   int            now = 0;
   int            ack_seen = 0;
   int            acc_seen = 0;
   int            stall_seen = 0;
   int            first_ack = -1;
   int            last_ack = -1;
   bit            prev_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, sample mid-cycle against the model, then advance.
   task automatic bus_cycle(input bit cyc, input bit stb, input bit we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [1:0] sel, output bit accepted);
      resp_t          r;
      bit             exp_ack;
      logic [MAW-1:0] a;
      wb_cyc_i = cyc;
      wb_stb_i = stb;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      #3;
      exp_ack = cyc && (rq.size() > 0) && (rq[0].t + LAT == now);
      if (exp_ack) begin
         r = rq.pop_front();
         if (!r.we) dat_exp = r.d;
      end
      check("ack", 32'(wb_ack_o), 32'(exp_ack));
      check("dat_o", 32'(wb_dat_o), 32'(dat_exp));
      if (!prev_en) check("stall_off", 32'(wb_stall_o), 32'd0);
      if (wb_ack_o) begin
         ack_seen++;
         if (first_ack < 0) first_ack = now;
         last_ack = now;
      end
      if (wb_stall_o) stall_seen++;
      if (!cyc) rq.delete();
      accepted = cyc && stb && !wb_stall_o;
      if (accepted) begin
         a = adr[MAW-1:0];
         acc_seen++;
         r.t  = now;
         r.we = we;
         r.d  = '0;
         if (we) begin
            for (int b = 0; b < 2; b++) begin
               if (sel[b]) mem_m[a][8*b +: 8] = dat[8*b +: 8];
            end
         end else begin
            r.d = mem_m[a];
         end
         rq.push_back(r);
      end
      prev_en = cfg_stall_en;
      @(posedge clk);
      #1;
      now++;
   endtask

   task automatic req(input bit we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat, input logic [1:0] sel);
      bit acc;
      int tries = 0;
      do begin
         bus_cycle(1'b1, 1'b1, we, adr, dat, sel, acc);
         tries++;
      end while (!acc && tries < 64);
      if (!acc) check("accept_bound", 32'(acc), 32'd1);
   endtask

   task automatic idle(input bit cyc, input int n);
      bit acc;
      for (int i = 0; i < n; i++) bus_cycle(cyc, 1'b0, 1'b0, '0, '0, 2'b00, acc);
   endtask

   task automatic drain();
      int n = 0;
      while (rq.size() > 0 && n < 32) begin
         idle(1'b1, 1);
         n++;
      end
      check("drain", 32'(rq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  lo;
      logic [13:0] hi;
      bit          we;
      int          burst_acks;

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      check("rst_ack", 32'(wb_ack_o), 32'd0);
      check("rst_dat", 32'(wb_dat_o), 32'd0);
      check("rst_stall", 32'(wb_stall_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write then read-after-write, ack 2 and 3 cycles later
      req(1'b1, 24'd5, 16'h1234, 2'b11);
      req(1'b0, 24'd5, 16'h0000, 2'b00);
      drain();
      check("raw_data", 32'(wb_dat_o), 32'h1234);

      // Burst: 8 writes then 8 reads, acks gap-free
      ack_seen  = 0;
      first_ack = -1;
      for (int i = 0; i < 8; i++) req(1'b1, 24'(i), 16'(16'hA000 + i), 2'b11);
      for (int i = 0; i < 8; i++) req(1'b0, 24'(i), 16'h0000, 2'b00);
      drain();
      burst_acks = ack_seen;
      check("burst_acks", 32'(burst_acks), 32'd16);
      check("burst_span", 32'(last_ack - first_ack + 1), 32'd16);
      check("burst_last", 32'(wb_dat_o), 32'hA007);

      // Byte enables
      req(1'b1, 24'd20, 16'hFFFF, 2'b11);
      req(1'b1, 24'd20, 16'h1200, 2'b10);
      req(1'b1, 24'd20, 16'h0034, 2'b00);
      req(1'b0, 24'd20, 16'h0000, 2'b00);
      drain();
      check("byte_en", 32'(wb_dat_o), 32'h12FF);

      // Abort: two reads, then drop wb_cyc_i
      req(1'b0, 24'd3, 16'h0000, 2'b00);
      req(1'b0, 24'd4, 16'h0000, 2'b00);
      ack_seen = 0;
      idle(1'b0, 4);
      check("abort_acks", 32'(ack_seen), 32'd0);
      req(1'b0, 24'd3, 16'h0000, 2'b00);
      drain();
      check("abort_reread", 32'(wb_dat_o), 32'hA003);

      // Aliasing above MAW
      req(1'b1, 24'h000400, 16'hBEEF, 2'b11);
      req(1'b0, 24'h000000, 16'h0000, 2'b00);
      drain();
      check("alias", 32'(wb_dat_o), 32'hBEEF);

      // Asynchronous reset with an ack on the bus
      req(1'b1, 24'd9, 16'h5A5A, 2'b11);
      drain();
      req(1'b0, 24'd9, 16'h0000, 2'b00);
      idle(1'b1, 1);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b0;
      #3;
      check("pre_rst_ack", 32'(wb_ack_o), 32'd1);
      check("pre_rst_dat", 32'(wb_dat_o), 32'h5A5A);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack", 32'(wb_ack_o), 32'd0);
      check("mid_rst_dat", 32'(wb_dat_o), 32'd0);
      check("mid_rst_stall", 32'(wb_stall_o), 32'd0);
      rq.delete();
      dat_exp = '0;
      prev_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      now++;
      ack_seen = 0;
      idle(1'b1, 4);
      check("post_rst_acks", 32'(ack_seen), 32'd0);
      req(1'b0, 24'd9, 16'h0000, 2'b00);
      drain();
      check("rst_keeps_ram", 32'(wb_dat_o), 32'h5A5A);

      // Randomized traffic with stall injection
      for (int i = 0; i < 32; i++) req(1'b1, 24'(i), 16'($urandom), 2'b11);
      drain();
      ack_seen   = 0;
      acc_seen   = 0;
      stall_seen = 0;
      cfg_stall_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         lo = 5'($urandom_range(31));
         hi = 14'($urandom);
         we = 1'($urandom_range(1));
         if ($urandom_range(4) == 0) idle(1'b1, 1);
         req(we, {hi, 5'b00000, lo}, 16'($urandom), 2'($urandom_range(3)));
      end
      cfg_stall_en = 1'b0;
      drain();
      idle(1'b1, 4);
      check("rand_acks", 32'(ack_seen), 32'(acc_seen));
      check("rand_stalls_seen", 32'(stall_seen > 0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
